booth_seq_mult: RTL

Parametrised sequential radix-2 Booth multiplier with valid/ready handshakes on both sides and per-operation signed/unsigned mode. It replaces the fixed 4×4 combinational Booth loop with a multi-cycle datapath of configurable width. It sits between an operand source (input pins or a register stage) and a result consumer that can apply backpressure.

---
 rtl/booth_pkg.sv | 15 +
 rtl/booth_seq_mult_if.sv | 24 ++
 rtl/booth_step.sv | 26 ++
 rtl/booth_seq_mult.sv | 88 ++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Iteration counter must hold 0..width (width+1 Booth steps).
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/booth_seq_mult_if.sv
// Operand/result handshake bundle for booth_seq_mult.
interface booth_seq_mult_if #(parameter int WIDTH = 8);
   logic                 in_valid;
   logic                 in_ready;
   logic                 in_signed;
   logic [WIDTH-1:0]     in_a;
   logic [WIDTH-1:0]     in_b;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out_product;
   logic                 busy;

   // Operand source / result consumer side.
   modport master (
      output in_valid, in_signed, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_product, busy
   );

   // Multiplier side.
   modport slave (
      input  in_valid, in_signed, in_a, in_b, out_ready,
      output in_ready, out_valid, out_product, busy
   );
endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/subtract M per {Q[0], q_m1}, then
// arithmetic right shift of {A, Q, q_m1}. Purely combinational.
module booth_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0] a,
   input  logic [WIDTH:0] q,
   input  logic           q_m1,
   input  logic [WIDTH:0] m,
   output logic [WIDTH:0] a_nx,
   output logic [WIDTH:0] q_nx,
   output logic           q_m1_nx
);
   logic [WIDTH:0] sum;

   // Recode the bit pair, then shift with A's MSB replicated.
   always_comb begin
      sum = a;
      case ({q[0], q_m1})
         2'b10:   sum = a - m;
         2'b01:   sum = a + m;
         default: sum = a;
      endcase
      {a_nx, q_nx, q_m1_nx} = {sum[WIDTH], sum, q};
   end
endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier, WIDTH+1 iterations per operation on
// operands extended by one bit so both signed and unsigned results are exact.
module booth_seq_mult
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   booth_seq_mult_if.slave bus
);
   localparam int CW = cnt_width(WIDTH);
   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_RUN  = RUN;
   localparam logic [1:0] S_DONE = DONE;

   logic [1:0]         state;
   logic               rst_q;
   logic [WIDTH:0]     m_r, a_r, q_r;
   logic               qm1_r;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] prod;

   logic [WIDTH:0]     a_nx, q_nx;
   logic               qm1_nx;
   logic [2*WIDTH-1:0] prod_nx;
   logic               accept;

   booth_step #(.WIDTH(WIDTH)) u_step (
      .a       (a_r),
      .q       (q_r),
      .q_m1    (qm1_r),
      .m       (m_r),
      .a_nx    (a_nx),
      .q_nx    (q_nx),
      .q_m1_nx (qm1_nx)
   );

   // Low 2*WIDTH bits of the post-step {A, Q}; the top two bits are redundant sign.
   assign prod_nx = {a_nx[WIDTH-2:0], q_nx};
   assign accept  = bus.in_valid && bus.in_ready;

   // Registered copy of reset keeps in_ready low during reset without a comb path from rst.
   always_ff @(posedge clk) begin
      rst_q <= rst;
   end

   // FSM, operand capture, iteration and result load.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         m_r   <= '0;
         a_r   <= '0;
         q_r   <= '0;
         qm1_r <= 1'b0;
         cnt   <= '0;
         prod  <= '0;
      end else begin
         case (state)
            S_IDLE: if (accept) begin
               m_r   <= {bus.in_signed & bus.in_a[WIDTH-1], bus.in_a};
               q_r   <= {bus.in_signed & bus.in_b[WIDTH-1], bus.in_b};
               a_r   <= '0;
               qm1_r <= 1'b0;
               cnt   <= '0;
               state <= S_RUN;
            end
            S_RUN: begin
               a_r   <= a_nx;
               q_r   <= q_nx;
               qm1_r <= qm1_nx;
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(WIDTH)) begin
                  prod  <= prod_nx;
                  state <= S_DONE;
               end
            end
            S_DONE: if (bus.out_ready) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready    = (state == S_IDLE) && !rst_q;
   assign bus.out_valid   = (state == S_DONE);
   assign bus.busy        = (state == S_RUN) || (state == S_DONE);
   assign bus.out_product = prod;
endmodule
